// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD pattern generator: RGB565 colours,
// bar palette, mode and state encodings, default raster geometry.
package lcd_pkg;

  localparam int DEF_H_RES     = 160;
  localparam int DEF_V_RES     = 80;
  localparam int DEF_BAR_W     = 20;
  localparam int DEF_CHK_SHIFT = 3;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t RGB_WHITE   = 16'hFFFF;
  localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
  localparam rgb565_t RGB_CYAN    = 16'h07FF;
  localparam rgb565_t RGB_GREEN   = 16'h07E0;
  localparam rgb565_t RGB_MAGENTA = 16'hF81F;
  localparam rgb565_t RGB_RED     = 16'hF800;
  localparam rgb565_t RGB_BLUE    = 16'h001F;
  localparam rgb565_t RGB_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Classic eight-bar test pattern, left to right.
  function automatic rgb565_t bar_color(input logic [2:0] idx);
    rgb565_t c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Pixel stream between the pattern generator (master) and the LCD SPI driver (slave).
interface lcd_pattern_gen_if;

  logic        PIX_VALID;
  logic        PIX_READY;
  logic [15:0] PIX_DATA;
  logic        PIX_SOF;
  logic        PIX_EOF;

  modport master (
    output PIX_VALID,
    output PIX_DATA,
    output PIX_SOF,
    output PIX_EOF,
    input  PIX_READY
  );

  modport slave (
    input  PIX_VALID,
    input  PIX_DATA,
    input  PIX_SOF,
    input  PIX_EOF,
    output PIX_READY
  );

endinterface

// File: rtl/lcd_raster_counter.sv
// Raster position counters (x, y, bar index/sub-count, pixel count) without dividers.
// The nxt_* outputs give the position that will be held after the coming clock edge.
module lcd_raster_counter
  import lcd_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter int BAR_W = DEF_BAR_W
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       clear,
  input  logic       advance,
  output logic [7:0] nxt_x,
  output logic [7:0] nxt_y,
  output logic [2:0] nxt_bar,
  output logic       nxt_is_first,
  output logic       nxt_is_last
);

  localparam int TOTAL = H_RES * V_RES;

  logic [7:0]  x, y, sub;
  logic [2:0]  bar;
  logic [13:0] cnt;
  logic [7:0]  nxt_sub;
  logic [13:0] nxt_cnt;

  // Clear wins over advance; the line wrap also realigns the bar counters.
  always_comb begin
    nxt_x   = x;
    nxt_y   = y;
    nxt_sub = sub;
    nxt_bar = bar;
    nxt_cnt = cnt;
    if (clear) begin
      nxt_x   = '0;
      nxt_y   = '0;
      nxt_sub = '0;
      nxt_bar = '0;
      nxt_cnt = '0;
    end else if (advance) begin
      nxt_cnt = cnt + 14'd1;
      if (x == 8'(H_RES - 1)) begin
        nxt_x   = '0;
        nxt_y   = y + 8'd1;
        nxt_sub = '0;
        nxt_bar = '0;
      end else begin
        nxt_x = x + 8'd1;
        if (sub == 8'(BAR_W - 1)) begin
          nxt_sub = '0;
          nxt_bar = bar + 3'd1;
        end else begin
          nxt_sub = sub + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      x   <= '0;
      y   <= '0;
      sub <= '0;
      bar <= '0;
      cnt <= '0;
    end else begin
      x   <= nxt_x;
      y   <= nxt_y;
      sub <= nxt_sub;
      bar <= nxt_bar;
      cnt <= nxt_cnt;
    end
  end

  assign nxt_is_first = (nxt_cnt == 14'd0);
  assign nxt_is_last  = (nxt_cnt == 14'(TOTAL - 1));

endmodule

// File: rtl/lcd_pattern_gen.sv
// Frame-at-a-time RGB565 test pattern source feeding the ST7735 SPI driver.
// Optional feature macro: GRADIENT_EN (mode 3 gradient plus frame counter).
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int BAR_W     = DEF_BAR_W,
  parameter int CHK_SHIFT = DEF_CHK_SHIFT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [1:0]        MODE,
  input  logic [15:0]       COLOR,
  output logic              BUSY,
  output logic              FRAME_DONE,
  lcd_pattern_gen_if.master pix
);

  state_e  state, state_nxt;
  mode_e   mode_q, mode_sel;
  rgb565_t color_q, color_sel, pix_nxt;

  logic       xfer, advance, clear;
  logic [7:0] nxt_x, nxt_y;
  logic [2:0] nxt_bar;
  logic       nxt_is_first, nxt_is_last;

  // The last pixel is never advanced past, so the counters stay in range after the frame.
  assign xfer    = pix.PIX_VALID && pix.PIX_READY;
  assign advance = xfer && !pix.PIX_EOF;
  assign clear   = (state == ST_LOAD);

  lcd_raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .BAR_W (BAR_W)
  ) u_raster (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .clear        (clear),
    .advance      (advance),
    .nxt_x        (nxt_x),
    .nxt_y        (nxt_y),
    .nxt_bar      (nxt_bar),
    .nxt_is_first (nxt_is_first),
    .nxt_is_last  (nxt_is_last)
  );

`ifdef GRADIENT_EN
  logic [7:0] frame_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      frame_cnt <= '0;
    end else if (state == ST_DONE) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{nxt_x, nxt_y, frame_cnt[7:5]};
`else
  logic unused_bits;
  assign unused_bits = ^{nxt_x, nxt_y};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (START) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_STREAM;
      ST_STREAM: if (xfer && pix.PIX_EOF) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // In LOAD the live MODE/COLOR inputs are used, since they are being latched on this same edge.
  always_comb begin
    mode_sel  = (state == ST_LOAD) ? mode_e'(MODE) : mode_q;
    color_sel = (state == ST_LOAD) ? COLOR : color_q;
    pix_nxt   = color_sel;
    case (mode_sel)
      MODE_SOLID:   pix_nxt = color_sel;
      MODE_BARS:    pix_nxt = bar_color(nxt_bar);
      MODE_CHECKER: pix_nxt = (nxt_x[CHK_SHIFT] ^ nxt_y[CHK_SHIFT]) ? RGB_BLACK : RGB_WHITE;
`ifdef GRADIENT_EN
      MODE_GRADIENT: pix_nxt = {nxt_x[7:3], nxt_y[6:1], frame_cnt[4:0]};
`else
      MODE_GRADIENT: pix_nxt = color_sel;
`endif
      default:      pix_nxt = color_sel;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      mode_q        <= MODE_SOLID;
      color_q       <= '0;
      BUSY          <= 1'b0;
      FRAME_DONE    <= 1'b0;
      pix.PIX_VALID <= 1'b0;
      pix.PIX_DATA  <= '0;
      pix.PIX_SOF   <= 1'b0;
      pix.PIX_EOF   <= 1'b0;
    end else begin
      state         <= state_nxt;
      BUSY          <= (state_nxt != ST_IDLE);
      FRAME_DONE    <= (state_nxt == ST_DONE);
      pix.PIX_VALID <= (state_nxt == ST_STREAM);
      if (state == ST_LOAD) begin
        mode_q  <= mode_e'(MODE);
        color_q <= COLOR;
      end
      if (clear || advance) begin
        pix.PIX_DATA <= pix_nxt;
        pix.PIX_SOF  <= nxt_is_first;
        pix.PIX_EOF  <= nxt_is_last;
      end else if (state_nxt == ST_DONE) begin
        pix.PIX_DATA <= '0;
        pix.PIX_SOF  <= 1'b0;
        pix.PIX_EOF  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed self-checking bench for lcd_pattern_gen (default 160x80 geometry).
module tb_lcd_pattern_gen;

  localparam int H     = 160;
  localparam int V     = 80;
  localparam int TOTAL = H * V;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [1:0]  MODE;
  logic [15:0] COLOR;
  logic        BUSY;
  logic        FRAME_DONE;

  int checks = 0;
  int errors = 0;

  logic [15:0] frame_buf [TOTAL];

  lcd_pattern_gen_if pix_if ();

  lcd_pattern_gen #(
    .H_RES     (H),
    .V_RES     (V),
    .BAR_W     (20),
    .CHK_SHIFT (3)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .MODE       (MODE),
    .COLOR      (COLOR),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE),
    .pix        (pix_if)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pixel colour, written from the pattern definitions rather than the RTL structure.
  function automatic logic [15:0] model_pix(input logic [1:0] m, input logic [15:0] c,
                                            input int x, input int y, input int fc);
    logic [15:0] r;
    case (m)
      2'd0: r = c;
      2'd1: begin
        case (x / 20)
          0: r = 16'hFFFF;
          1: r = 16'hFFE0;
          2: r = 16'h07FF;
          3: r = 16'h07E0;
          4: r = 16'hF81F;
          5: r = 16'hF800;
          6: r = 16'h001F;
          default: r = 16'h0000;
        endcase
      end
      2'd2: r = ((((x / 8) + (y / 8)) % 2) == 1) ? 16'h0000 : 16'hFFFF;
      default: begin
`ifdef GRADIENT_EN
        r = {5'(x / 8), 6'(y / 2), 5'(fc % 32)};
`else
        r = c;
`endif
      end
    endcase
    return r;
  endfunction

  // Runs one whole frame from a START pulse; call on a negative edge with the DUT idle.
  task automatic applyStimulus(input string nm, input logic [1:0] m, input logic [15:0] c,
                               input int ready_pct, input bit mid_start, input int fc);
    int xfers = 0, cyc = 0;
    int pix_bad = 0, sof_bad = 0, eof_bad = 0, valid_bad = 0, busy_bad = 0;
    int stall_bad = 0, done_bad = 0, stalls = 0;
    bit stalled = 0, rdy;
    logic [15:0] held_d;
    logic held_s, held_e;

    MODE = m;
    COLOR = c;
    START = 1'b1;
    pix_if.PIX_READY = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    checkOutput({nm, "_busy_load"}, 32'(BUSY), 32'd1);
    checkOutput({nm, "_valid_load"}, 32'(pix_if.PIX_VALID), 32'd0);
    @(negedge CLK);
    checkOutput({nm, "_sof_first"}, 32'(pix_if.PIX_SOF), 32'd1);

    while (xfers < TOTAL && cyc < TOTAL * 4) begin
      if (pix_if.PIX_VALID !== 1'b1) valid_bad++;
      if (BUSY !== 1'b1) busy_bad++;
      if (FRAME_DONE !== 1'b0) done_bad++;
      if (stalled && (pix_if.PIX_DATA !== held_d || pix_if.PIX_SOF !== held_s ||
                      pix_if.PIX_EOF !== held_e)) stall_bad++;
      rdy = (ready_pct >= 100) || ($urandom_range(0, 99) < ready_pct);
      pix_if.PIX_READY = rdy;
      START = 1'b0;
      if (mid_start && xfers == 6000 && rdy) begin
        START = 1'b1;
        MODE  = 2'd1;
        COLOR = 16'h1234;
      end
      if (pix_if.PIX_VALID === 1'b1 && rdy) begin
        frame_buf[xfers] = pix_if.PIX_DATA;
        if (pix_if.PIX_DATA !== model_pix(m, c, xfers % H, xfers / H, fc)) pix_bad++;
        if (pix_if.PIX_SOF !== (xfers == 0)) sof_bad++;
        if (pix_if.PIX_EOF !== (xfers == TOTAL - 1)) eof_bad++;
        xfers++;
        stalled = 0;
      end else begin
        stalled = 1;
        stalls++;
        held_d = pix_if.PIX_DATA;
        held_s = pix_if.PIX_SOF;
        held_e = pix_if.PIX_EOF;
      end
      @(negedge CLK);
      cyc++;
    end
    START = 1'b0;
    pix_if.PIX_READY = 1'b0;

    checkOutput({nm, "_xfers"}, 32'(xfers), 32'(TOTAL));
    checkOutput({nm, "_pix_bad"}, 32'(pix_bad), 32'd0);
    checkOutput({nm, "_sof_bad"}, 32'(sof_bad), 32'd0);
    checkOutput({nm, "_eof_bad"}, 32'(eof_bad), 32'd0);
    checkOutput({nm, "_valid_drop"}, 32'(valid_bad), 32'd0);
    checkOutput({nm, "_busy_drop"}, 32'(busy_bad), 32'd0);
    checkOutput({nm, "_done_early"}, 32'(done_bad), 32'd0);
    if (ready_pct < 100) begin
      checkOutput({nm, "_stall_unstable"}, 32'(stall_bad), 32'd0);
      checkOutput({nm, "_stalls_seen"}, 32'(stalls > 0), 32'd1);
    end

    checkOutput({nm, "_done_m1"}, 32'(FRAME_DONE), 32'd1);
    checkOutput({nm, "_busy_m1"}, 32'(BUSY), 32'd1);
    checkOutput({nm, "_valid_m1"}, 32'(pix_if.PIX_VALID), 32'd0);
    @(negedge CLK);
    checkOutput({nm, "_done_m2"}, 32'(FRAME_DONE), 32'd0);
    checkOutput({nm, "_busy_m2"}, 32'(BUSY), 32'd0);
    @(negedge CLK);
    checkOutput({nm, "_busy_m3"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int xfers, cyc, diffs;
    logic [15:0] grad_exp0, grad_exp1;

    $display("[TB] start");
    RST_N = 1'b0;
    START = 1'b0;
    MODE  = 2'd0;
    COLOR = 16'h0000;
    pix_if.PIX_READY = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("rst_busy", 32'(BUSY), 32'd0);
    checkOutput("rst_valid", 32'(pix_if.PIX_VALID), 32'd0);
    checkOutput("rst_data", 32'(pix_if.PIX_DATA), 32'h0);
    checkOutput("rst_sof", 32'(pix_if.PIX_SOF), 32'd0);
    checkOutput("rst_eof", 32'(pix_if.PIX_EOF), 32'd0);
    checkOutput("rst_done", 32'(FRAME_DONE), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

`ifdef GRADIENT_EN
    grad_exp0 = 16'h9CE0;
    grad_exp1 = 16'h9CE1;
`else
    grad_exp0 = 16'h07E0;
    grad_exp1 = 16'h07E0;
`endif

    // Gradient frame 0 with a START/MODE/COLOR change injected mid-frame
    applyStimulus("grad0", 2'd3, 16'h07E0, 100, 1'b1, 0);
    checkOutput("grad0_last", 32'(frame_buf[TOTAL-1]), 32'(grad_exp0));
    checkOutput("grad0_after_midstart", 32'(frame_buf[7000]), 32'(model_pix(2'd3, 16'h07E0, 7000 % H, 7000 / H, 0)));

    applyStimulus("grad1", 2'd3, 16'h07E0, 100, 1'b0, 1);
    checkOutput("grad1_last", 32'(frame_buf[TOTAL-1]), 32'(grad_exp1));

    applyStimulus("solid", 2'd0, 16'hF800, 100, 1'b0, 2);
    checkOutput("solid_first", 32'(frame_buf[0]), 32'hF800);
    checkOutput("solid_last", 32'(frame_buf[TOTAL-1]), 32'hF800);

    applyStimulus("bars", 2'd1, 16'h0000, 100, 1'b0, 3);
    checkOutput("bars_x0", 32'(frame_buf[0]), 32'hFFFF);
    checkOutput("bars_x19", 32'(frame_buf[19]), 32'hFFFF);
    checkOutput("bars_x20", 32'(frame_buf[20]), 32'hFFE0);
    checkOutput("bars_x159", 32'(frame_buf[159]), 32'h0000);
    diffs = 0;
    for (int i = 0; i < H; i++) if (frame_buf[i] !== frame_buf[(V - 1) * H + i]) diffs++;
    checkOutput("bars_row79_diffs", 32'(diffs), 32'd0);

    applyStimulus("chk", 2'd2, 16'h0000, 75, 1'b0, 4);
    checkOutput("chk_0_0", 32'(frame_buf[0]), 32'hFFFF);
    checkOutput("chk_8_0", 32'(frame_buf[8]), 32'h0000);
    checkOutput("chk_8_8", 32'(frame_buf[8 * H + 8]), 32'hFFFF);

    // Reset in the middle of a frame, then a fresh frame must restart at (0,0)
    MODE  = 2'd1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    pix_if.PIX_READY = 1'b1;
    xfers = 0;
    cyc = 0;
    while (xfers < 5000 && cyc < 20000) begin
      if (pix_if.PIX_VALID === 1'b1) xfers++;
      @(negedge CLK);
      cyc++;
    end
    checkOutput("mid_xfers", 32'(xfers), 32'd5000);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    pix_if.PIX_READY = 1'b0;
    checkOutput("mrst_busy", 32'(BUSY), 32'd0);
    checkOutput("mrst_valid", 32'(pix_if.PIX_VALID), 32'd0);
    checkOutput("mrst_data", 32'(pix_if.PIX_DATA), 32'h0);
    checkOutput("mrst_sof", 32'(pix_if.PIX_SOF), 32'd0);
    checkOutput("mrst_eof", 32'(pix_if.PIX_EOF), 32'd0);
    checkOutput("mrst_done", 32'(FRAME_DONE), 32'd0);
    @(negedge CLK);
    checkOutput("mrst_idle_busy", 32'(BUSY), 32'd0);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    checkOutput("restart_valid", 32'(pix_if.PIX_VALID), 32'd1);
    checkOutput("restart_sof", 32'(pix_if.PIX_SOF), 32'd1);
    checkOutput("restart_data", 32'(pix_if.PIX_DATA), 32'hFFFF);
    pix_if.PIX_READY = 1'b1;
    @(negedge CLK);
    checkOutput("restart_px1_sof", 32'(pix_if.PIX_SOF), 32'd0);
    checkOutput("restart_px1_data", 32'(pix_if.PIX_DATA), 32'hFFFF);
    pix_if.PIX_READY = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
